// File: rtl/enc8b10b_stream.sv
// Streaming multi-lane 8b/10b encoder with chained running disparity, K28.5 alignment
// preamble and valid/ready handshake. Optional build macro: IDLE_COMMA_EN (idle K28.5 fill in RUN).
module enc8b10b_stream #(
    parameter int NUM_BYTES   = 2,
    parameter int ALIGN_WORDS = 16,
    parameter int CW          = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*NUM_BYTES-1:0]  s_data,
    input  logic [NUM_BYTES-1:0]    s_k,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [10*NUM_BYTES-1:0] m_data,
    output logic                    rd_o,
    output logic                    illegal_k_o,
    output logic                    align_done_o
);

    localparam logic [CW-1:0] ALIGN_LAST = CW'(ALIGN_WORDS - 1);
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    K28_5      = 8'hBC;

    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                    state_r;
    logic [CW-1:0]             align_cnt_r;
    logic                      m_valid_r;
    logic [10*NUM_BYTES-1:0]   m_data_r;
    logic                      rd_r;
    logic                      illegal_k_r;
    logic                      align_done_r;

    logic [8*NUM_BYTES-1:0]    src_data_s;
    logic [NUM_BYTES-1:0]      src_k_s;
    logic                      src_valid_s;
    logic                      slot_free_s;
    logic                      load_s;
    logic [10*NUM_BYTES-1:0]   enc_data_s;
    logic [NUM_BYTES-1:0]      illegal_lane_s;
    logic                      lane_rd_s;
    logic [10:0]               lane_enc_s;
    logic                      word_rd_s;

    // 5b/6b table, RD- column written as abcdei (a in the MSB)
    function automatic logic [5:0] lut_5b6b(input logic [4:0] x, input logic k);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = k ? 6'b001111 : 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            5'd31:   c = 6'b101011;
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    // 3b/4b table, RD- column written as fghj; alt7 selects the A7 form of x.7
    function automatic logic [3:0] lut_3b4b(input logic [2:0] y, input logic k, input logic alt7);
        logic [3:0] c;
        if (k) begin
            case (y)
                3'd0:    c = 4'b1011;
                3'd1:    c = 4'b0110;
                3'd2:    c = 4'b1010;
                3'd3:    c = 4'b1100;
                3'd4:    c = 4'b1101;
                3'd5:    c = 4'b0101;
                3'd6:    c = 4'b1001;
                3'd7:    c = 4'b0111;
                default: c = 4'b0000;
            endcase
        end else begin
            case (y)
                3'd0:    c = 4'b1011;
                3'd1:    c = 4'b1001;
                3'd2:    c = 4'b0101;
                3'd3:    c = 4'b1100;
                3'd4:    c = 4'b1101;
                3'd5:    c = 4'b1010;
                3'd6:    c = 4'b0110;
                3'd7:    c = alt7 ? 4'b0111 : 4'b1110;
                default: c = 4'b0000;
            endcase
        end
        return c;
    endfunction

    function automatic logic is_balanced6(input logic [5:0] c);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, c[i]};
        end
        return (n == 3'd3);
    endfunction

    function automatic logic is_balanced4(input logic [3:0] c);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, c[i]};
        end
        return (n == 3'd2);
    endfunction

    function automatic logic k_legal(input logic [7:0] b);
        logic [4:0] x;
        logic [2:0] y;
        x = b[4:0];
        y = b[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    endfunction

    // Returns {rd_out, symbol}; symbol bit 0 = a ... bit 9 = j
    function automatic logic [10:0] encode_symbol(input logic [7:0] b, input logic k, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6_m;
        logic [5:0] c6;
        logic [3:0] c4_m;
        logic [3:0] c4;
        logic       unb6;
        logic       unb4;
        logic       rd_mid;
        logic       alt7;
        logic       flip4;
        logic [9:0] raw;
        logic [9:0] sym;
        x      = b[4:0];
        y      = b[7:5];
        c6_m   = lut_5b6b(x, k);
        unb6   = !is_balanced6(c6_m);
        // D7 is balanced but still alternates with RD
        c6     = (rd_in && (unb6 || (c6_m == 6'b111000))) ? ~c6_m : c6_m;
        rd_mid = rd_in ^ unb6;
        alt7   = k ||
                 (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                 ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        c4_m   = lut_3b4b(y, k, alt7);
        unb4   = !is_balanced4(c4_m);
        flip4  = k || unb4 || (y == 3'd3);
        c4     = (rd_mid && flip4) ? ~c4_m : c4_m;
        raw    = {c6, c4};
        for (int i = 0; i < 10; i++) begin
            sym[i] = raw[9-i];
        end
        return {rd_mid ^ unb4, sym};
    endfunction

    // Source selection: internal comma during ALIGN, upstream (or idle comma) in RUN
    always_comb begin
        src_data_s  = {NUM_BYTES{K28_5}};
        src_k_s     = {NUM_BYTES{1'b1}};
        src_valid_s = 1'b0;
        if (state_r == ST_ALIGN) begin
            src_valid_s = 1'b1;
        end else begin
`ifdef IDLE_COMMA_EN
            if (s_valid) begin
                src_data_s  = s_data;
                src_k_s     = s_k;
                src_valid_s = 1'b1;
            end else begin
                src_valid_s = 1'b1;
            end
`else
            src_data_s  = s_data;
            src_k_s     = s_k;
            src_valid_s = s_valid;
`endif
        end
    end

    assign slot_free_s = !m_valid_r || m_ready;
    assign load_s      = slot_free_s && src_valid_s;
    assign s_ready     = (state_r == ST_RUN) && slot_free_s;

    // Lane encoders with disparity chained from lane 0 upward
    always_comb begin
        enc_data_s     = '0;
        illegal_lane_s = '0;
        lane_enc_s     = 11'd0;
        lane_rd_s      = rd_r;
        for (int n = 0; n < NUM_BYTES; n++) begin
            lane_enc_s              = encode_symbol(src_data_s[8*n +: 8], src_k_s[n], lane_rd_s);
            enc_data_s[10*n +: 10]  = lane_enc_s[9:0];
            illegal_lane_s[n]       = src_k_s[n] && !k_legal(src_data_s[8*n +: 8]);
            lane_rd_s               = lane_enc_s[10];
        end
        word_rd_s = lane_rd_s;
    end

    // Output register, RD register and ALIGN/RUN state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ALIGN;
            align_cnt_r  <= '0;
            m_valid_r    <= 1'b0;
            m_data_r     <= '0;
            rd_r         <= 1'b0;
            illegal_k_r  <= 1'b0;
            align_done_r <= 1'b0;
        end else begin
            if (load_s) begin
                m_valid_r   <= 1'b1;
                m_data_r    <= enc_data_s;
                illegal_k_r <= |illegal_lane_s;
                rd_r        <= word_rd_s;
            end else if (m_ready) begin
                m_valid_r <= 1'b0;
            end
            case (state_r)
                ST_ALIGN: begin
                    if (load_s) begin
                        align_cnt_r <= align_cnt_r + CNT_ONE;
                        if (align_cnt_r == ALIGN_LAST) begin
                            state_r      <= ST_RUN;
                            align_done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    align_done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_ALIGN;
                end
            endcase
        end
    end

    assign m_valid      = m_valid_r;
    assign m_data       = m_data_r;
    assign rd_o         = rd_r;
    assign illegal_k_o  = illegal_k_r;
    assign align_done_o = align_done_r;

endmodule
